// File: rtl/cg_ptw_pkg.sv
// Shared types and default widths for the page-table-walker arbiter.
// Requesters and the walker use the request/response structs at the default widths.
package cg_ptw_pkg;

  localparam int PTW_NUM_REQ = 2;
  localparam int PTW_VADDR_W = 39;
  localparam int PTW_PADDR_W = 56;
  localparam int PTW_ASID_W  = 16;
  localparam int PTW_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } ptw_state_e;

  typedef struct packed {
    logic [PTW_VADDR_W-1:0] vaddr;
    logic [PTW_ASID_W-1:0]  asid;
  } ptw_req_t;

  typedef struct packed {
    logic [PTW_PADDR_W-1:0] paddr;
    logic                   fault;
  } ptw_rsp_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cg_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Produces both a one-hot grant and its binary index.
module cg_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int   cand;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found                  = 1'b1;
        grant[IDX_W'(cand)]    = 1'b1;
        grant_idx              = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cg_ptw_arbiter.sv
// Shares one page-table walker among NUM_REQ TLB miss requesters with round-robin
// arbitration, a walk timeout and a flush/drain path; all outputs are registered.
module cg_ptw_arbiter
  import cg_ptw_pkg::*;
#(
  parameter int NUM_REQ        = PTW_NUM_REQ,
  parameter int VADDR_WIDTH    = PTW_VADDR_W,
  parameter int PADDR_WIDTH    = PTW_PADDR_W,
  parameter int ASID_WIDTH     = PTW_ASID_W,
  parameter int TIMEOUT_CYCLES = PTW_TIMEOUT
) (
  input  logic                                  i_clk,
  input  logic                                  i_rstn,
  input  logic [NUM_REQ-1:0]                    i_req_miss,
  input  logic [NUM_REQ-1:0][VADDR_WIDTH-1:0]   i_req_vaddr,
  input  logic [NUM_REQ-1:0][ASID_WIDTH-1:0]    i_req_asid,
  output logic [NUM_REQ-1:0]                    o_rsp_valid,
  output logic [PADDR_WIDTH-1:0]                o_rsp_paddr,
  output logic                                  o_rsp_fault,
  output logic                                  o_ptw_req,
  output logic [VADDR_WIDTH-1:0]                o_ptw_vaddr,
  output logic [ASID_WIDTH-1:0]                 o_ptw_asid,
  input  logic                                  i_ptw_ready,
  input  logic                                  i_ptw_valid,
  input  logic [PADDR_WIDTH-1:0]                i_ptw_paddr,
  input  logic                                  i_ptw_fault,
  input  logic                                  i_flush,
  output logic                                  o_busy
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  ptw_state_e               state_q, state_d;
  logic [IW-1:0]            ptr_q;
  logic [NUM_REQ-1:0]       gnt_q;
  logic [CW-1:0]            cnt_q;
  logic [NUM_REQ-1:0]       pick_onehot;
  logic [IW-1:0]            pick_idx;
  logic [IW-1:0]            ptr_next;
  logic                     expired;
  logic                     grant_now;
  logic                     rsp_load;
  logic [PADDR_WIDTH-1:0]   rsp_paddr_d;
  logic                     rsp_fault_d;

  cg_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_rr (
    .req       (i_req_miss),
    .ptr       (ptr_q),
    .grant     (pick_onehot),
    .grant_idx (pick_idx)
  );

  assign expired  = (cnt_q == CNT_LAST);
  assign ptr_next = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);

  always_comb begin
    state_d     = state_q;
    grant_now   = 1'b0;
    rsp_load    = 1'b0;
    rsp_paddr_d = '0;
    rsp_fault_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|i_req_miss) begin
          grant_now = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An accepted request must be drained even when flushed in the same cycle.
        if (i_ptw_ready)  state_d = i_flush ? S_DRAIN : S_WAIT;
        else if (i_flush) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (i_flush) begin
          state_d = S_DRAIN;
        end else if (i_ptw_valid) begin
          state_d     = S_RESP;
          rsp_load    = 1'b1;
          rsp_paddr_d = i_ptw_paddr;
          rsp_fault_d = i_ptw_fault;
        end else if (expired) begin
          state_d     = S_RESP;
          rsp_load    = 1'b1;
          rsp_fault_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_DRAIN: if (i_ptw_valid || expired) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      o_rsp_valid <= '0;
      o_rsp_paddr <= '0;
      o_rsp_fault <= 1'b0;
      o_ptw_req   <= 1'b0;
      o_ptw_vaddr <= '0;
      o_ptw_asid  <= '0;
      o_busy      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        ptr_q       <= ptr_next;
        gnt_q       <= pick_onehot;
        o_ptw_vaddr <= i_req_vaddr[pick_idx];
        o_ptw_asid  <= i_req_asid[pick_idx];
      end
      // Counter restarts while issuing and saturates rather than wrapping.
      if (state_q == S_ISSUE)
        cnt_q <= '0;
      else if ((state_q == S_WAIT || state_q == S_DRAIN) && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CW'(1);
      o_ptw_req   <= (state_d == S_ISSUE);
      o_busy      <= (state_d != S_IDLE);
      o_rsp_valid <= rsp_load ? gnt_q : '0;
      if (rsp_load) begin
        o_rsp_paddr <= rsp_paddr_d;
        o_rsp_fault <= rsp_fault_d;
      end
    end
  end

endmodule
